// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART RX control path: FSM state encoding,
// frame bit indices and the legal oversampling ratios.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } rx_state_e;

  localparam logic [3:0] BIT_START = 4'd1;
  localparam logic [3:0] BIT_D0    = 4'd2;
  localparam logic [3:0] BIT_D7    = 4'd9;
  localparam logic [3:0] BIT_PAR   = 4'd10;

  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  function automatic logic prescale_legal(input int unsigned p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and frame bit counter for the UART RX sequencer.
// Priority: clear > load_one > enable.
module uart_rx_edge_bit_cnt
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_clear,
  input  logic                  i_load_one,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic [PRESCALE_W-1:0] o_edge_cnt,
  output logic [3:0]            o_bit_cnt,
  output logic                  o_last_edge
);

  logic [PRESCALE_W-1:0] r_edge;
  logic [3:0]            r_bit;

  assign o_last_edge = (r_edge == i_prescale - PRESCALE_W'(1));
  assign o_edge_cnt  = r_edge;
  assign o_bit_cnt   = r_bit;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_edge <= '0;
      r_bit  <= '0;
    end else if (i_load_one) begin
      r_edge <= '0;
      r_bit  <= BIT_START;
    end else if (i_enable) begin
      if (o_last_edge) begin
        r_edge <= '0;
        r_bit  <= r_bit + 4'd1;
      end else begin
        r_edge <= r_edge + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX sequencer: start detection, bit timing, parity/stop checking, data_valid.
// Optional UART_RX_ERR_CNT_EN adds a saturating err_cnt output.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  sampled_bit,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  dat_samp_en,
  output logic                  deser_en,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  strt_glitch
`ifdef UART_RX_ERR_CNT_EN
  ,
  output logic [7:0]            err_cnt
`endif
);

  localparam logic [3:0] LAST_DATA_BIT = 4'(BIT_D7 + DATA_WIDTH - 8);

  rx_state_e             r_state, w_next;
  logic [PRESCALE_W-1:0] r_prescale;
  logic                  r_par_acc, r_par_err, r_stp_err;
  logic                  w_last_edge, w_frame_start, w_cnt_en, w_cnt_clr, w_glitch;

  uart_rx_edge_bit_cnt #(.PRESCALE_W(PRESCALE_W)) u_cnt (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_enable   (w_cnt_en),
    .i_clear    (w_cnt_clr),
    .i_load_one (w_frame_start),
    .i_prescale (r_prescale),
    .o_edge_cnt (edge_cnt),
    .o_bit_cnt  (bit_cnt),
    .o_last_edge(w_last_edge)
  );

  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_frame_start = 1'b0;
    w_cnt_en      = 1'b0;
    w_cnt_clr     = 1'b0;
    w_glitch      = 1'b0;
    dat_samp_en   = 1'b0;
    deser_en      = 1'b0;
    data_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!RX_IN) begin
          w_next        = ST_START;
          w_frame_start = 1'b1;
        end
      end
      ST_START: begin
        dat_samp_en = 1'b1;
        w_cnt_en    = 1'b1;
        if (w_last_edge) begin
          if (sampled_bit) begin
            w_glitch  = 1'b1;
            w_cnt_clr = 1'b1;
            w_next    = ST_IDLE;
          end else begin
            w_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        dat_samp_en = 1'b1;
        w_cnt_en    = 1'b1;
        if (w_last_edge) begin
          deser_en = 1'b1;
          if (bit_cnt == LAST_DATA_BIT) w_next = PAR_EN ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        dat_samp_en = 1'b1;
        w_cnt_en    = 1'b1;
        if (w_last_edge) w_next = ST_STOP;
      end
      ST_STOP: begin
        dat_samp_en = 1'b1;
        w_cnt_en    = 1'b1;
        if (w_last_edge) w_next = ST_DONE;
      end
      ST_DONE: begin
        data_valid = ~(r_par_err | r_stp_err);
        if (!RX_IN) begin
          w_next        = ST_START;
          w_frame_start = 1'b1;
        end else begin
          w_next    = ST_IDLE;
          w_cnt_clr = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Prescale is latched on every frame start, including back-to-back DONE -> START.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_prescale <= PRESCALE_W'(PRESCALE_8);
      r_par_acc  <= 1'b0;
      r_par_err  <= 1'b0;
      r_stp_err  <= 1'b0;
    end else if (w_frame_start) begin
      r_prescale <= prescale_legal(32'(Prescale)) ? Prescale : PRESCALE_W'(PRESCALE_8);
      r_par_acc  <= 1'b0;
      r_par_err  <= 1'b0;
      r_stp_err  <= 1'b0;
    end else if (w_last_edge) begin
      case (r_state)
        ST_DATA:   r_par_acc <= r_par_acc ^ sampled_bit;
        ST_PARITY: r_par_err <= sampled_bit ^ r_par_acc ^ PAR_TYP;
        ST_STOP:   r_stp_err <= ~sampled_bit;
        default:   ;
      endcase
    end
  end

  assign par_err     = r_par_err;
  assign stp_err     = r_stp_err;
  assign strt_glitch = w_glitch;

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_err_cnt <= '0;
    end else if ((w_glitch || (r_state == ST_DONE && (r_par_err || r_stp_err)))
                 && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl; err_cnt checks when UART_RX_ERR_CNT_EN is defined.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST, RX_IN, PAR_EN, PAR_TYP, sampled_bit;
  logic [5:0] Prescale, edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en, deser_en, data_valid, par_err, stp_err, strt_glitch;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  int n_vec = 0, n_miss = 0, cyc = 0, t0 = 0;
  int n_deser = 0, n_dv = 0, n_gl = 0, dv_cyc = 0, gl_cyc = 0;
  int bd, bv, bg;
  logic [3:0] deser_bc [0:1023];
  logic [7:0] dv_byte  [0:255];
  logic [7:0] rx_sh = '0;
  logic [7:0] d5;

  uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .Prescale(Prescale), .sampled_bit(sampled_bit), .edge_cnt(edge_cnt),
    .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en), .deser_en(deser_en),
    .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err),
    .strt_glitch(strt_glitch)
`ifdef UART_RX_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Event log sampled on the falling edge, away from DUT state updates.
  always @(negedge CLK) begin
    if (deser_en) begin
      deser_bc[n_deser % 1024] = bit_cnt;
      rx_sh = {sampled_bit, rx_sh[7:1]};
      n_deser++;
    end
    if (data_valid) begin
      dv_byte[n_dv % 256] = rx_sh;
      dv_cyc = cyc;
      n_dv++;
    end
    if (strt_glitch) begin
      gl_cyc = cyc;
      n_gl++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_edge(input logic [5:0] pin, input logic pe, input logic pt);
    @(negedge CLK);
    RX_IN = 1'b0; sampled_bit = 1'b0; Prescale = pin; PAR_EN = pe; PAR_TYP = pt;
    t0 = cyc;
    @(posedge CLK);
  endtask

  task automatic drive_bit(input logic b, input int unsigned p);
    @(negedge CLK);
    RX_IN = b; sampled_bit = b;
    repeat (p) @(posedge CLK);
  endtask

  task automatic frame_body(input logic [7:0] data, input int unsigned p, input logic pe,
                            input logic par_bit, input logic stop_bit);
    @(negedge CLK);
    RX_IN = 1'b0; sampled_bit = 1'b0;
    Prescale = (p == 8) ? 6'd16 : 6'd8;
    repeat (p) @(posedge CLK);
    for (int i = 0; i < 8; i++) drive_bit(data[i], p);
    if (pe) drive_bit(par_bit, p);
    drive_bit(stop_bit, p);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic [5:0] pin, input int unsigned p,
                            input logic pe, input logic pt, input logic par_bit,
                            input logic stop_bit);
    start_edge(pin, pe, pt);
    frame_body(data, p, pe, par_bit, stop_bit);
  endtask

  task automatic idle(input int unsigned n);
    @(negedge CLK);
    RX_IN = 1'b1; sampled_bit = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic glitch_start();
    @(negedge CLK);
    Prescale = 6'd8; RX_IN = 1'b0; sampled_bit = 1'b0;
    t0 = cyc;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RX_IN = 1'b1; sampled_bit = 1'b1;
    repeat (12) @(posedge CLK);
    #1;
  endtask

  task automatic check_good(input int base_d, input int base_v, input logic [7:0] data,
                            input int lat);
    chk("dv_count", n_dv - base_v, 1);
    chk("dv_byte", dv_byte[base_v % 256], data);
    chk("dv_latency", dv_cyc - t0, lat);
    chk("deser_count", n_deser - base_d, 8);
    for (int i = 0; i < 8; i++) chk("deser_bitcnt", deser_bc[(base_d + i) % 1024], i + 2);
  endtask

  initial begin
    RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8; sampled_bit = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_edge_cnt", edge_cnt, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    chk("rst_samp_en", dat_samp_en, 0);
    chk("rst_deser_en", deser_en, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_par_err", par_err, 0);
    chk("rst_stp_err", stp_err, 0);
    chk("rst_glitch", strt_glitch, 0);
    @(negedge CLK);
    RST = 1'b0;
    idle(3);

    // P=8, no parity, 0xA5
    bd = n_deser; bv = n_dv;
    send_frame(8'hA5, 6'd8, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("t1_dv_done", data_valid, 1);
    chk("t1_par_err", par_err, 0);
    chk("t1_stp_err", stp_err, 0);
    idle(3);
    check_good(bd, bv, 8'hA5, 81);
    chk("t1_idle_bit_cnt", bit_cnt, 0);

    // P=16, even parity, 0x03 with wrong parity bit
    bv = n_dv;
    send_frame(8'h03, 6'd16, 16, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    chk("t2_par_err", par_err, 1);
    chk("t2_dv_done", data_valid, 0);
    chk("t2_stp_err", stp_err, 0);
    idle(3);
    chk("t2_dv_count", n_dv - bv, 0);
    chk("t2_par_sticky", par_err, 1);
    bd = n_deser; bv = n_dv;
    start_edge(6'd16, 1'b1, 1'b0);
    #1;
    chk("t2_par_clr", par_err, 0);
    frame_body(8'h03, 16, 1'b1, 1'b0, 1'b1);
    idle(3);
    check_good(bd, bv, 8'h03, 177);

    // Start glitch
    bd = n_deser; bg = n_gl;
    glitch_start();
    chk("t3_glitch_count", n_gl - bg, 1);
    chk("t3_glitch_time", gl_cyc - t0, 8);
    chk("t3_bit_cnt", bit_cnt, 0);
    chk("t3_edge_cnt", edge_cnt, 0);
    chk("t3_samp_en", dat_samp_en, 0);
    chk("t3_deser", n_deser - bd, 0);

    // Stop error, then back-to-back 0x55 / 0xFF starting in DONE
    bd = n_deser; bv = n_dv;
    send_frame(8'h3C, 6'd8, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("t4_stp_err", stp_err, 1);
    chk("t4_dv_done", data_valid, 0);
    chk("t4_par_err", par_err, 0);
    start_edge(6'd8, 1'b0, 1'b0);
    #1;
    chk("t4_stp_clr", stp_err, 0);
    chk("t4_b2b_bit_cnt", bit_cnt, 1);
    chk("t4_b2b_edge_cnt", edge_cnt, 0);
    chk("t4_b2b_samp_en", dat_samp_en, 1);
    frame_body(8'h55, 8, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 6'd8, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    chk("t4_dv_count", n_dv - bv, 2);
    chk("t4_byte0", dv_byte[bv % 256], 8'h55);
    chk("t4_byte1", dv_byte[(bv + 1) % 256], 8'hFF);
    chk("t4_latency", dv_cyc - t0, 81);
    chk("t4_deser_count", n_deser - bd, 24);

    // Reset mid-frame at bit_cnt 5
    bv = n_dv; d5 = 8'h96;
    start_edge(6'd8, 1'b0, 1'b0);
    drive_bit(1'b0, 8);
    for (int i = 0; i < 3; i++) drive_bit(d5[i], 8);
    @(negedge CLK);
    RX_IN = d5[3]; sampled_bit = d5[3];
    repeat (3) @(posedge CLK);
    #1;
    chk("t5_bit_cnt_pre", bit_cnt, 5);
    @(negedge CLK);
    RST = 1'b1; RX_IN = 1'b1; sampled_bit = 1'b1;
    @(posedge CLK);
    #1;
    chk("t5_edge_cnt", edge_cnt, 0);
    chk("t5_bit_cnt", bit_cnt, 0);
    chk("t5_samp_en", dat_samp_en, 0);
    chk("t5_deser_en", deser_en, 0);
    chk("t5_data_valid", data_valid, 0);
    @(negedge CLK);
    RST = 1'b0;
    idle(100);
    chk("t5_no_dv", n_dv - bv, 0);
    bd = n_deser; bv = n_dv;
    send_frame(8'h96, 6'd32, 32, 1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    chk("t5_odd_par_err", par_err, 0);
    idle(3);
    check_good(bd, bv, 8'h96, 353);

    // Illegal prescale falls back to 8
    bd = n_deser; bv = n_dv;
    send_frame(8'h81, 6'd12, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    check_good(bd, bv, 8'h81, 81);

`ifdef UART_RX_ERR_CNT_EN
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("t6_err_cnt_rst", err_cnt, 0);
    glitch_start();
    chk("t6_err_cnt_one", err_cnt, 1);
    for (int k = 1; k < 300; k++) glitch_start();
    chk("t6_err_cnt_sat", err_cnt, 255);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("t6_err_cnt_clr", err_cnt, 0);
    @(negedge CLK);
    RST = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side sequencer for the UART RX path.
- Detects the start bit, runs the oversampling edge counter and the frame bit counter, and drives the enables for the data sampler and the deserializer.
- Checks start, parity and stop bits, then flags a good byte with a one-cycle data_valid.
- Sits between the RX_IN pin (already synchronized) and the sampler/deserializer datapath, in the UART RX clock domain.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame; bit_cnt encoding below assumes 8.
- PRESCALE_W, 6, width of the Prescale input.

Ports:
- CLK  in  1  RX clock (oversampling clock)
- RST  in  1  reset: one clock; reset is synchronous and active-high
- RX_IN  in  1  serial line, idle high
- PAR_EN  in  1  1 = parity bit present
- PAR_TYP  in  1  0 = even parity, 1 = odd parity
- Prescale  in  PRESCALE_W  oversampling ratio; legal values 8, 16, 32
- sampled_bit  in  1  majority-voted bit from the sampler
- edge_cnt  out  PRESCALE_W  oversampling edge index within the current bit
- bit_cnt  out  4  frame bit index: 1 = start, 2..9 = data LSB-first, 10 = parity or stop, 11 = stop when parity is enabled
- dat_samp_en  out  1  sampler enable
- deser_en  out  1  one-cycle capture strobe to the deserializer
- data_valid  out  1  one-cycle pulse: byte good
- par_err  out  1  sticky until next frame start
- stp_err  out  1  sticky until next frame start
- strt_glitch  out  1  one-cycle pulse

Behaviour:
- Reset (synchronous, RST=1 at CLK edge):
  - state = IDLE.
  - edge_cnt = 0, bit_cnt = 0.
  - All enables, error outputs and data_valid = 0.
  - Parity accumulator = 0.
  - Reset mid-frame aborts the frame immediately; no data_valid is produced.
- Prescale latching:
  - Prescale is latched on IDLE -> START.
  - Mid-frame changes are ignored.
  - An illegal latched value is treated as 8.
- Sample point: "last edge" means edge_cnt == P-1, where P is the latched prescale. sampled_bit is valid there.
- Counting in all states except IDLE and DONE:
  - edge_cnt wraps from P-1 to 0.
  - bit_cnt increments on each wrap.
- dat_samp_en = 1 in START, DATA, PARITY and STOP; 0 otherwise.
- States and transitions:
  - IDLE: when RX_IN == 0, go to START. Set edge_cnt = 0, bit_cnt = 1; clear par_err, stp_err and the parity accumulator.
  - START: at last edge:
    - sampled_bit == 1: pulse strt_glitch for one cycle, go to IDLE, bit_cnt = 0.
    - otherwise go to DATA.
  - DATA: at each last edge:
    - deser_en = 1 for that cycle; the parity accumulator XORs in sampled_bit.
    - After bit_cnt 9: go to PARITY if PAR_EN, else STOP.
  - PARITY: at last edge, par_err = sampled_bit XOR accumulator XOR PAR_TYP. Then go to STOP.
  - STOP: at last edge, stp_err = ~sampled_bit. Then go to DONE.
  - DONE (exactly 1 cycle):
    - data_valid = ~(par_err | stp_err).
    - edge_cnt = 0.
    - RX_IN == 0: go straight to START (back-to-back frames), bit_cnt = 1, errors cleared.
    - Otherwise go to IDLE, bit_cnt = 0.
- Latency:
  - data_valid asserts 1 cycle after the stop-bit last edge.
  - A frame occupies (10 + PAR_EN) × P + 1 cycles from the start edge.
- PAR_EN and PAR_TYP are sampled live. They must be held stable for the whole frame; changing them mid-frame is out of spec.

Optional Feature:
- Macro: UART_RX_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt [7:0], a saturating count of frames ending with par_err, stp_err or strt_glitch.
  - Increments in the DONE cycle, or in the strt_glitch cycle.
  - Saturates at 255. Cleared only by RST.
- Undefined: no err_cnt port and no counter logic; all other behaviour is identical.

Decomposition:
- Package uart_rx_pkg:
  - State encoding (IDLE, START, DATA, PARITY, STOP, DONE).
  - Bit-index constants BIT_START=1, BIT_D0=2, BIT_D7=9, BIT_PAR=10.
  - Legal prescale constants 8/16/32.
- Sub-module uart_rx_edge_bit_cnt:
  - Holds edge_cnt and bit_cnt, with inputs enable, clear, load_one and prescale.
  - Outputs last_edge.
  - The FSM stays in uart_rx_ctrl.

Test Plan:
- Prescale=8, PAR_EN=0, frame 0xA5 with a good stop bit -> deser_en pulses exactly 8 times at bit_cnt 2..9; data_valid = 1 for one cycle, 81 cycles after the start edge; par_err = stp_err = 0.
- Prescale=16, PAR_EN=1, PAR_TYP=0, byte 0x03, parity bit 1 -> par_err = 1, data_valid never asserts; the next good frame clears par_err at its start.
- RX_IN low for 3 cycles then high (Prescale=8, sampled_bit=1 at edge 7) -> strt_glitch pulses once, FSM returns to IDLE, bit_cnt = 0, no deser_en.
- Stop bit sampled 0 -> stp_err = 1, no data_valid; RX_IN low in the DONE cycle -> START entered directly, back-to-back 0x55 then 0xFF both received.
- RST=1 asserted at bit_cnt = 5 mid-frame -> next cycle: state IDLE, all outputs 0, no data_valid; a following frame is received normally.
- With UART_RX_ERR_CNT_EN: 300 glitched starts -> err_cnt saturates at 255; RST -> err_cnt = 0.
